// File: rtl/prog_lut_pkg.sv
// Shared types and helpers for the programmable LUT evaluator.
package prog_lut_pkg;

   typedef enum logic {
      READY = 1'b0,
      LOAD  = 1'b1
   } state_t;

   function automatic int tbl_w(input int nin);
      return 1 << nin;
   endfunction

endpackage

// File: rtl/prog_lut_eval_if.sv
// Configuration and evaluation bus of the LUT evaluator.
interface prog_lut_eval_if #(
   parameter int NIN = 3
) ();
   logic           cfg_start;
   logic           cfg_abort;
   logic           cfg_valid;
   logic           cfg_bit;
   logic           cfg_busy;
   logic           in_valid;
   logic [NIN-1:0] in_data;
   logic           out_valid;
   logic           out_bit;

   modport master (
      output cfg_start, cfg_abort, cfg_valid, cfg_bit, in_valid, in_data,
      input  cfg_busy, out_valid, out_bit
   );

   modport slave (
      input  cfg_start, cfg_abort, cfg_valid, cfg_bit, in_valid, in_data,
      output cfg_busy, out_valid, out_bit
   );
endinterface

// File: rtl/prog_lut_eval_cfg_shift.sv
// Shadow table and bit counter for serial table loading, index 0 first.
// shadow reflects the table as it will be after the current edge, so a commit can capture the last bit.
module lut_cfg_shift
   import prog_lut_pkg::*;
#(
   parameter int NIN = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   valid,
   input  logic                   data_bit,
   output logic                   done,
   output logic [tbl_w(NIN)-1:0]  shadow
);
   localparam int TW = tbl_w(NIN);
   localparam int CW = NIN + 1;

   logic [TW-1:0] shadow_q;
   logic [CW-1:0] count;

   always_comb begin
      shadow = shadow_q;
      for (int i = 0; i < TW; i++)
         if (valid && count == CW'(i)) shadow[i] = data_bit;
   end

   assign done = valid && (count == CW'(TW - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         count    <= '0;
      end else if (clear) begin
         shadow_q <= '0;
         count    <= '0;
      end else if (valid) begin
         shadow_q <= shadow;
         count    <= count + 1'b1;
      end
   end

endmodule

// File: rtl/prog_lut_eval.sv
// Programmable NIN-input boolean function: serially loaded truth table, one result per cycle.
module prog_lut_eval
   import prog_lut_pkg::*;
#(
   parameter int                     NIN  = 3,
   parameter logic [tbl_w(NIN)-1:0]  INIT = 8'h7E
) (
   input  logic               clk,
   input  logic               rst_n,
   prog_lut_eval_if.slave     bus
);
   localparam int TW = tbl_w(NIN);

   state_t        state, state_nxt;
   logic          clear, acc, done;
   logic [TW-1:0] shadow, active;
   logic          busy, out_valid, out_bit;

   // abort wins over a coincident bit
   assign acc = (state == LOAD) && bus.cfg_valid && !bus.cfg_abort;

   lut_cfg_shift #(.NIN(NIN)) u_cfg (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .valid    (acc),
      .data_bit (bus.cfg_bit),
      .done     (done),
      .shadow   (shadow)
   );

   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      case (state)
         READY: if (bus.cfg_start) begin
            state_nxt = LOAD;
            clear     = 1'b1;
         end
         LOAD: if (bus.cfg_abort || done) state_nxt = READY;
         default: state_nxt = READY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= READY;
         busy   <= 1'b0;
         active <= INIT;
      end else begin
         state <= state_nxt;
         busy  <= (state == LOAD);
         if (done) active <= shadow;
      end
   end

   // evaluation reads the pre-commit table on a coincident edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
      end else begin
         out_valid <= bus.in_valid;
         if (bus.in_valid) out_bit <= active[bus.in_data];
      end
   end

   assign bus.cfg_busy  = busy;
   assign bus.out_valid = out_valid;
   assign bus.out_bit   = out_bit;

endmodule

// File: tb/tb_prog_lut_eval.sv
// Random and directed checks of two evaluators (NIN=3 and NIN=4) sharing one config stream.
module tb_prog_lut_eval;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       st, ab, cv, cb, iv;
   logic [3:0] din;

   prog_lut_eval_if #(.NIN(3)) b3 ();
   prog_lut_eval_if #(.NIN(4)) b4 ();

   assign b3.cfg_start = st;  assign b4.cfg_start = st;
   assign b3.cfg_abort = ab;  assign b4.cfg_abort = ab;
   assign b3.cfg_valid = cv;  assign b4.cfg_valid = cv;
   assign b3.cfg_bit   = cb;  assign b4.cfg_bit   = cb;
   assign b3.in_valid  = iv;  assign b4.in_valid  = iv;
   assign b3.in_data   = din[2:0];
   assign b4.in_data   = din;

   prog_lut_eval #(.NIN(3), .INIT(8'h7E)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
   prog_lut_eval #(.NIN(4), .INIT(16'h8001)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

   // reference: table contents, load-in-progress flag and bits received so far
   int          tw [2] = '{8, 16};
   logic [15:0] m_init [2] = '{16'h007E, 16'h8001};
   logic [15:0] m_tbl [2];
   logic [15:0] m_sh [2];
   int          m_n [2];
   bit          m_load [2];
   logic        e_ov [2], e_ob [2], e_busy [2];

   int n_cmp = 0;
   int n_err = 0;
   int busy_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic mdl_reset();
      for (int k = 0; k < 2; k++) begin
         m_tbl[k] = m_init[k]; m_sh[k] = '0; m_n[k] = 0; m_load[k] = 1'b0;
         e_ov[k] = 1'b0; e_ob[k] = 1'b0; e_busy[k] = 1'b0;
      end
   endtask

   task automatic mdl_edge();
      for (int k = 0; k < 2; k++) begin
         e_ov[k] = iv;
         if (iv) e_ob[k] = m_tbl[k][int'(din) % tw[k]];
         e_busy[k] = m_load[k];
         if (!m_load[k]) begin
            if (st) begin m_load[k] = 1'b1; m_n[k] = 0; m_sh[k] = '0; end
         end else if (ab) begin
            m_load[k] = 1'b0;
         end else if (cv) begin
            m_sh[k][m_n[k]] = cb;
            m_n[k]++;
            if (m_n[k] == tw[k]) begin m_tbl[k] = m_sh[k]; m_load[k] = 1'b0; end
         end
      end
   endtask

   task automatic check_all();
      chk("ov3",   b3.out_valid, e_ov[0]);
      chk("ob3",   b3.out_bit,   e_ob[0]);
      chk("busy3", b3.cfg_busy,  e_busy[0]);
      chk("ov4",   b4.out_valid, e_ov[1]);
      chk("ob4",   b4.out_bit,   e_ob[1]);
      chk("busy4", b4.cfg_busy,  e_busy[1]);
   endtask

   task automatic cyc(input logic s, input logic a, input logic v, input logic b,
                      input logic i, input logic [3:0] d);
      st = s; ab = a; cv = v; cb = b; iv = i; din = d;
      @(posedge clk);
      mdl_edge();
      @(negedge clk);
      check_all();
      if (b3.cfg_busy) busy_cnt++;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 4'd0);
   endtask

   task automatic eval(input logic [3:0] d);
      cyc(0, 0, 0, 0, 1, d);
   endtask

   // asserted between edges to exercise the asynchronous path
   task automatic do_reset(input int dly);
      st = 0; ab = 0; cv = 0; cb = 0; iv = 0; din = 0;
      #dly rst_n = 1'b0;
      #1 mdl_reset();
      check_all();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [7:0] r031 = 8'b0111_1110;
   int gaps;

   initial begin
      st = 0; ab = 0; cv = 0; cb = 0; iv = 0; din = 0;
      mdl_reset();
      @(negedge clk);
      #1 check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // INIT table, back-to-back from the first edge after reset
      for (int i = 0; i < 8; i++) begin
         eval(4'(i));
         chk("r031_ov", b3.out_valid, 1'b1);
         chk("r031_ob", b3.out_bit, r031[i]);
      end

      // abort after 4 bits keeps INIT; abort beats a coincident bit
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0, 0);
      cyc(0, 1, 1, 1, 0, 0);
      eval(4'd0);
      chk("r033_ob0", b3.out_bit, 1'b0);
      chk("r033_busy", b3.cfg_busy, 1'b0);
      eval(4'd7);
      chk("r033_ob7", b3.out_bit, 1'b0);

      // load 1000_0000 with gaps in cfg_valid
      busy_cnt = 0; gaps = 0;
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         int g = $urandom_range(0, 2);
         gaps += g;
         for (int j = 0; j < g; j++) cyc(0, 0, 0, $urandom_range(0, 1), 0, 0);
         cyc(0, 0, 1, (i == 7), 0, 0);
      end
      eval(4'd7);
      chk("r032_ob7", b3.out_bit, 1'b1);
      eval(4'd3);
      chk("r032_ob3", b3.out_bit, 1'b0);
      chk("r032_busy_cycles", busy_cnt, 8 + gaps);

      // commit coincident with an evaluation uses the old table
      do_reset(3);
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 1, 1, 4'd7);
      chk("r034_old", b3.out_bit, 1'b0);
      eval(4'd7);
      chk("r034_new", b3.out_bit, 1'b1);

      // reset mid-load reverts to INIT
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0, 0);
      do_reset(2);
      eval(4'd0);
      chk("r035_ob0", b3.out_bit, 1'b0);
      chk("r036_ob0", b4.out_bit, 1'b1);
      eval(4'd7);
      chk("r035_ob7", b3.out_bit, 1'b0);
      eval(4'd15);
      chk("r036_ob15", b4.out_bit, 1'b1);
      eval(4'd5);
      chk("r036_ob5", b4.out_bit, 1'b0);

      // 16-bit load: NIN=4 commits only on the 16th bit
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         cyc(0, 0, 1, 1, 1, 4'd6);
         if (i == 15) chk("r036_busy_last", b4.cfg_busy, 1'b1);
      end
      chk("r036_pre", b4.out_bit, 1'b0);
      eval(4'd6);
      chk("r036_load", b4.out_bit, 1'b1);
      eval(4'd6);
      chk("r036_busy_off", b4.cfg_busy, 1'b0);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         if (n == 700) do_reset($urandom_range(1, 4));
         cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
             $urandom_range(0, 1), $urandom_range(0, 1),
             ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
